// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
// Optional macro REGFILE_WB_RR_EN selects round-robin arbitration.
package regfile_pkg;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback requesters, the arbiter and the regfile.
// Handshake: a transfer happens in a cycle where reqN_valid_i && reqN_ready_o;
// ready is combinational, and a requester holds addr/data while valid && !ready.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                 req0_valid_i;
  logic [REG_IDX_W-1:0] req0_addr_i;
  logic [DATA_W-1:0]    req0_data_i;
  logic                 req0_ready_o;
  logic                 req1_valid_i;
  logic [REG_IDX_W-1:0] req1_addr_i;
  logic [DATA_W-1:0]    req1_data_i;
  logic                 req1_ready_o;
  logic                 w_en_o;
  logic [DATA_W-1:0]    w_addr_o;
  logic [DATA_W-1:0]    w_data_o;
  logic [REG_IDX_W-1:0] r_addr_p1_i;
  logic [REG_IDX_W-1:0] r_addr_p2_i;
  logic                 fwd_p1_valid_o;
  logic                 fwd_p2_valid_o;
  logic [DATA_W-1:0]    fwd_data_o;
  logic [CNT_W-1:0]     grant_cnt_o;

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_data_i,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    input  r_addr_p1_i, r_addr_p2_i,
    output req0_ready_o, req1_ready_o,
    output w_en_o, w_addr_o, w_data_o,
    output fwd_p1_valid_o, fwd_p2_valid_o, fwd_data_o, grant_cnt_o
  );

  modport master (
    output req0_valid_i, req0_addr_i, req0_data_i,
    output req1_valid_i, req1_addr_i, req1_data_i,
    output r_addr_p1_i, r_addr_p2_i,
    input  req0_ready_o, req1_ready_o,
    input  w_en_o, w_addr_o, w_data_o,
    input  fwd_p1_valid_o, fwd_p2_valid_o, fwd_data_o, grant_cnt_o
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way single-grant arbiter. REGFILE_WB_RR_EN: round-robin on last_grant;
// otherwise fixed priority with port 0 winning every conflict.
module rr_arb2 (
`ifdef REGFILE_WB_RR_EN
  input  logic       clk,
`endif
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
`ifdef REGFILE_WB_RR_EN
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_o        = 2'b00;
    last_grant_d = last_grant_q;
    if (!reset) begin
      if (req_i == 2'b11) begin
        gnt_o = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
    // Every grant is a transfer because ready equals grant.
    if (gnt_o != 2'b00) begin
      last_grant_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    gnt_o = 2'b00;
    if (!reset) begin
      gnt_o = {req_i[1] & ~req_i[0], req_i[0]};
    end
  end
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the regfile write port with same-cycle read forwarding.
// Optional macro REGFILE_WB_RR_EN enables round-robin instead of port-0 priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  bus
);
  wb_req_t req0;
  wb_req_t req1;
  wb_req_t sel;
  logic [1:0] gnt;
  logic       xfer;

  logic                 w_en_q,   w_en_d;
  logic [REG_IDX_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0]    w_data_q, w_data_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;

  assign req0 = '{valid: bus.req0_valid_i, addr: bus.req0_addr_i, data: bus.req0_data_i};
  assign req1 = '{valid: bus.req1_valid_i, addr: bus.req1_addr_i, data: bus.req1_data_i};

  rr_arb2 u_arb (
`ifdef REGFILE_WB_RR_EN
    .clk   (clk),
`endif
    .reset (reset),
    .req_i ({req1.valid, req0.valid}),
    .gnt_o (gnt)
  );

  assign bus.req0_ready_o = gnt[0];
  assign bus.req1_ready_o = gnt[1];

  always_comb begin
    sel      = gnt[1] ? req1 : req0;
    xfer     = (gnt != 2'b00) && sel.valid;
    // Writes to x0 complete the handshake but never reach the regfile.
    w_en_d   = xfer && (sel.addr != REG_ZERO);
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (w_en_d) begin
      w_addr_d = sel.addr;
      w_data_d = sel.data;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, w_en_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.w_en_o      = w_en_q;
  assign bus.w_addr_o    = {{(DATA_W-REG_IDX_W){1'b0}}, w_addr_q};
  assign bus.w_data_o    = w_data_q;
  assign bus.grant_cnt_o = cnt_q;

  // A write still sitting in the output register is dropped under reset, so it must not forward.
  assign bus.fwd_p1_valid_o = !reset && w_en_q && (w_addr_q == bus.r_addr_p1_i);
  assign bus.fwd_p2_valid_o = !reset && w_en_q && (w_addr_q == bus.r_addr_p2_i);
  assign bus.fwd_data_o     = w_data_q;
endmodule
